branch_predictor: RTL and testbench

Branch target buffer with per-entry saturating direction counters; it lets the pipeline predict branches and jumps at fetch instead of resolving them in EX and then flushing IF/ID and ID/EX. The datapath looks up the fetch PC combinationally in IF and selects the next PC from the prediction. EX-stage resolution then trains the table and reports mispredicts.

---
 rtl/aww_types_pkg.sv | 14 +
 rtl/branch_predictor_sat_counter.sv | 32 +++
 rtl/branch_predictor.sv | 153 +++++++++++++++
 tb/tb_branch_predictor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aww_types_pkg.sv
// Shared types and defaults for the branch predictor slice.
// The BTB entry layout depends on module parameters, so btb_entry_t is declared inside branch_predictor.
package aww_types_pkg;

    localparam int BP_ENTRIES_DEFAULT = 16;
    localparam int BP_CTR_W_DEFAULT   = 2;
    localparam int BP_WORD_W_DEFAULT  = 32;

    // Weakly-taken counter value for a freshly allocated entry: MSB set, rest clear.
    function automatic int unsigned bp_weak_taken(input int unsigned ctr_w);
        return 32'd1 << (ctr_w - 32'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Combinational saturating up/down counter next-value used on the BTB update path.
module bp_sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             inc,
    output logic [CTR_W-1:0] ctr_next
);

    localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN = {CTR_W{1'b0}};

    // Step toward the outcome, holding at either rail.
    always_comb begin
        ctr_next = ctr;
        if (inc) begin
            if (ctr != CTR_MAX) begin
                ctr_next = ctr + CTR_ONE;
            end else begin
                ctr_next = CTR_MAX;
            end
        end else begin
            if (ctr != CTR_MIN) begin
                ctr_next = ctr - CTR_ONE;
            end else begin
                ctr_next = CTR_MIN;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with saturating direction counters: combinational IF lookup, EX-stage training.
// Optional statistics ports/counters are built when BRANCH_PREDICTOR_STATS_EN is defined.
module branch_predictor
    import aww_types_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES_DEFAULT,
    parameter int WORD_W  = BP_WORD_W_DEFAULT,
    parameter int CTR_W   = BP_CTR_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [WORD_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [WORD_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [WORD_W-1:0] upd_target,
    input  logic              upd_mispredict,
`ifdef BRANCH_PREDICTOR_STATS_EN
    input  logic              lookup_en,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_updates,
    output logic [31:0]       stat_mispredicts,
`endif
    input  logic              bp_clear
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = WORD_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WEAK_TAKEN = CTR_W'(bp_weak_taken(CTR_W));

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [WORD_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } btb_entry_t;

    btb_entry_t btb_r [ENTRIES];

    logic [IDX_W-1:0] lk_idx_s;
    logic [TAG_W-1:0] lk_tag_s;
    btb_entry_t       lk_entry_s;
    logic [IDX_W-1:0] up_idx_s;
    logic [TAG_W-1:0] up_tag_s;
    btb_entry_t       up_entry_s;
    logic             up_hit_s;
    logic [CTR_W-1:0] ctr_next_s;
    logic             wr_en_s;
    btb_entry_t       wr_entry_s;
    logic             unused_s;

    // Byte offset bits never participate in indexing or tagging.
    assign unused_s = ^{lookup_pc[1:0], upd_pc[1:0], upd_mispredict};

    // Fetch-side lookup reads the array directly; a same-cycle write is not bypassed.
    always_comb begin
        lk_idx_s    = lookup_pc[IDX_W+1:2];
        lk_tag_s    = lookup_pc[WORD_W-1:IDX_W+2];
        lk_entry_s  = btb_r[lk_idx_s];
        pred_hit    = lk_entry_s.valid && (lk_entry_s.tag == lk_tag_s);
        pred_taken  = pred_hit && lk_entry_s.ctr[CTR_W-1];
        if (pred_hit) begin
            pred_target = lk_entry_s.target;
        end else begin
            pred_target = {WORD_W{1'b0}};
        end
    end

    bp_sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
        .ctr      (up_entry_s.ctr),
        .inc      (upd_taken),
        .ctr_next (ctr_next_s)
    );

    // Build the single write for a resolved branch: train on hit, allocate on taken miss.
    always_comb begin
        up_idx_s   = upd_pc[IDX_W+1:2];
        up_tag_s   = upd_pc[WORD_W-1:IDX_W+2];
        up_entry_s = btb_r[up_idx_s];
        up_hit_s   = up_entry_s.valid && (up_entry_s.tag == up_tag_s);
        wr_en_s    = 1'b0;
        wr_entry_s = up_entry_s;
        if (upd_valid) begin
            if (up_hit_s) begin
                wr_en_s        = 1'b1;
                wr_entry_s.ctr = ctr_next_s;
                if (upd_taken) begin
                    wr_entry_s.target = upd_target;
                end else begin
                    wr_entry_s.target = up_entry_s.target;
                end
            end else if (upd_taken) begin
                wr_en_s           = 1'b1;
                wr_entry_s.valid  = 1'b1;
                wr_entry_s.tag    = up_tag_s;
                wr_entry_s.target = upd_target;
                wr_entry_s.ctr    = CTR_WEAK_TAKEN;
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Entry array: reset and clear only drop valid bits; clear beats a same-cycle update.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_r[i].valid <= 1'b0;
            end
        end else if (bp_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_r[i].valid <= 1'b0;
            end
        end else if (wr_en_s) begin
            btb_r[up_idx_s] <= wr_entry_s;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_lookups_r;
    logic [31:0] stat_updates_r;
    logic [31:0] stat_mispredicts_r;

    // Free-running event counters; updates dropped by bp_clear still count.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stat_lookups_r     <= 32'd0;
            stat_updates_r     <= 32'd0;
            stat_mispredicts_r <= 32'd0;
        end else begin
            if (lookup_en) begin
                stat_lookups_r <= stat_lookups_r + 32'd1;
            end
            if (upd_valid) begin
                stat_updates_r <= stat_updates_r + 32'd1;
            end
            if (upd_valid && upd_mispredict) begin
                stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
            end
        end
    end

    assign stat_lookups     = stat_lookups_r;
    assign stat_updates     = stat_updates_r;
    assign stat_mispredicts = stat_mispredicts_r;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (16 entries, 32-bit PC, 2-bit counters).
// Directed test-plan sequences plus randomized traffic against an array-based reference model.
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] lookup_pc = 32'd0;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'd0;
    logic        upd_mispredict = 1'b0;
    logic        bp_clear = 1'b0;
    logic        lookup_en = 1'b0;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: per-slot valid/tag/target and an integer confidence in 0..3.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_lookups, m_updates, m_mispredicts;

    branch_predictor dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .lookup_pc      (lookup_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
`ifdef BRANCH_PREDICTOR_STATS_EN
        .lookup_en        (lookup_en),
        .stat_lookups     (stat_lookups),
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts),
`endif
        .bp_clear       (bp_clear)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_lookups = 32'd0;
        m_updates = 32'd0;
        m_mispredicts = 32'd0;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output logic hit, output logic tk, output logic [31:0] tgt);
        int idx;
        idx = int'((pc / 4) % 16);
        hit = m_valid[idx] && (m_tag[idx] == pc / 64);
        tk  = hit && (m_ctr[idx] >= 2);
        tgt = hit ? m_tgt[idx] : 32'd0;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        int idx;
        idx = int'((pc / 4) % 16);
        if (m_valid[idx] && m_tag[idx] == pc / 64) begin
            if (tk) begin
                m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                m_tgt[idx] = tgt;
            end else begin
                m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
            end
        end else if (tk) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = pc / 64;
            m_tgt[idx]   = tgt;
            m_ctr[idx]   = 2;
        end
    endtask

    task automatic check_lookup_model(input string tag);
        logic h, t;
        logic [31:0] g;
        model_lookup(lookup_pc, h, t, g);
        check({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, h});
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, t});
        check({tag, "_target"}, pred_target, g);
    endtask

    task automatic check_stats();
`ifdef BRANCH_PREDICTOR_STATS_EN
        check("stat_lookups", stat_lookups, m_lookups);
        check("stat_updates", stat_updates, m_updates);
        check("stat_mispredicts", stat_mispredicts, m_mispredicts);
`endif
    endtask

    // One clock: lookup is checked pre-edge against the pre-update model, then the model advances.
    task automatic cycle(input logic rst_n_i, input logic [31:0] lpc, input logic len,
                         input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic umis, input logic clr);
        nRST = rst_n_i; lookup_pc = lpc; lookup_en = len;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        upd_mispredict = umis; bp_clear = clr;
        #2;
        if (rst_n_i) check_lookup_model("cyc");
        @(posedge CLK);
        #1;
        if (!rst_n_i) begin
            model_reset();
        end else begin
            if (len) m_lookups = m_lookups + 32'd1;
            if (uv) m_updates = m_updates + 32'd1;
            if (uv && umis) m_mispredicts = m_mispredicts + 32'd1;
            if (clr) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            end else if (uv) begin
                model_update(upc, ut, utgt);
            end
        end
        nRST = 1'b1; upd_valid = 1'b0; bp_clear = 1'b0; lookup_en = 1'b0; upd_mispredict = 1'b0;
        check_stats();
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        cycle(1'b1, 32'd0, 1'b0, 1'b1, pc, tk, tgt, 1'b0, 1'b0);
    endtask

    // Directed lookup with spec-derived constants, also cross-checked against the model.
    task automatic expect_lookup(input string tag, input logic [31:0] pc, input logic h,
                                 input logic t, input logic [31:0] tgt);
        lookup_pc = pc;
        upd_valid = 1'b0;
        #2;
        check({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, h});
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, t});
        check({tag, "_target"}, pred_target, tgt);
        check_lookup_model(tag);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tg, ix, lo;
        tg = 32'($urandom_range(0, 3));
        ix = 32'($urandom_range(0, 15));
        lo = 32'($urandom_range(0, 3));
        return (tg << 6) | (ix << 2) | lo;
    endfunction

    initial begin
        logic [31:0] lpc, upc;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            m_tag[i] = 0; m_tgt[i] = 32'd0; m_ctr[i] = 0;
        end
        nRST = 1'b0;
        @(posedge CLK); @(posedge CLK);
        #1;
        nRST = 1'b1;

        expect_lookup("reset", 32'h0000_0040, 1'b0, 1'b0, 32'd0);
        check_stats();

        upd(32'h40, 1'b1, 32'h100);
        expect_lookup("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
        expect_lookup("alias", 32'h80, 1'b0, 1'b0, 32'd0);

        upd(32'h40, 1'b0, 32'h999);
        expect_lookup("nt1", 32'h40, 1'b1, 1'b0, 32'h100);
        upd(32'h40, 1'b0, 32'h999);
        expect_lookup("nt2", 32'h40, 1'b1, 1'b0, 32'h100);
        upd(32'h40, 1'b0, 32'h999);
        expect_lookup("nt3", 32'h40, 1'b1, 1'b0, 32'h100);
        for (int i = 0; i < 4; i++) upd(32'h40, 1'b1, 32'h100);
        expect_lookup("sat_hi", 32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0);
        expect_lookup("sat_dn1", 32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0);
        expect_lookup("sat_dn2", 32'h40, 1'b1, 1'b0, 32'h100);

        // Same-cycle lookup/update: cycle() checks the old entry before the edge.
        cycle(1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 1'b0);
        expect_lookup("bypass_after", 32'h40, 1'b1, 1'b1, 32'h200);

        upd(32'h44, 1'b1, 32'h300);
        upd(32'h48, 1'b1, 32'h304);
        upd(32'h4C, 1'b1, 32'h308);
        expect_lookup("pop", 32'h48, 1'b1, 1'b1, 32'h304);
        cycle(1'b1, 32'h0, 1'b0, 1'b1, 32'h60, 1'b1, 32'h400, 1'b0, 1'b1);
        expect_lookup("clr40", 32'h40, 1'b0, 1'b0, 32'd0);
        expect_lookup("clr44", 32'h44, 1'b0, 1'b0, 32'd0);
        expect_lookup("clr4c", 32'h4C, 1'b0, 1'b0, 32'd0);
        expect_lookup("clr60", 32'h60, 1'b0, 1'b0, 32'd0);

        // Mid-operation reset overrides a simultaneous allocate.
        upd(32'h40, 1'b1, 32'h100);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h44, 1'b1, 32'h500, 1'b1, 1'b0);
        expect_lookup("rst40", 32'h40, 1'b0, 1'b0, 32'd0);
        expect_lookup("rst44", 32'h44, 1'b0, 1'b0, 32'd0);

`ifdef BRANCH_PREDICTOR_STATS_EN
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h10, 1'b0, 1'b0);
        cycle(1'b1, 32'h0, 1'b0, 1'b1, 32'h84, 1'b0, 32'h10, 1'b1, 1'b0);
        cycle(1'b1, 32'h0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h10, 1'b0, 1'b0);
        check("plan_lookups", stat_lookups, 32'd5);
        check("plan_updates", stat_updates, 32'd3);
        check("plan_mispredicts", stat_mispredicts, 32'd1);
        force dut.stat_updates_r = 32'hFFFF_FFFF;
        #1;
        release dut.stat_updates_r;
        m_updates = 32'hFFFF_FFFF;
        upd(32'h88, 1'b0, 32'h0);
        check("wrap_updates", stat_updates, 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            lpc = rand_pc();
            upc = ($urandom_range(0, 1) == 0) ? lpc : rand_pc();
            cycle(1'b1, lpc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), upc,
                  1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 31) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
